// File: rtl/controller_v2_if.sv
`default_nettype none
// ============================================================================
//  Module      : controller_v2_if
//  Description : Bundle between the RV32I multicycle control FSM and the
//                instruction register / datapath it steers.
//  Revision    : 1.0 - initial release
// ============================================================================
interface controller_v2_if;
  // Instruction-register fields, status and memory handshakes
  logic       start;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       branch_cond;
  logic       imem_ready;
  logic       dmem_ready;
  // Datapath controls and status
  logic       imem_req;
  logic       dmem_req;
  logic       dmem_we;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_op;
  logic       reg_write;
  logic [1:0] wb_sel;
  logic       instret;
  logic       trap;
  logic [1:0] trap_cause;
  logic [2:0] state_vec;

  // Controller side
  modport master (
    input  start, opcode, funct3, funct7, branch_cond, imem_ready, dmem_ready,
    output imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, instret,
           trap, trap_cause, state_vec
  );

  // Datapath / memory side
  modport slave (
    output start, opcode, funct3, funct7, branch_cond, imem_ready, dmem_ready,
    input  imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src,
           alu_src_a, alu_src_b, alu_op, reg_write, wb_sel, instret,
           trap, trap_cause, state_vec
  );
endinterface
`default_nettype wire

// File: rtl/controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : controller_v2
//  Description : Multicycle RV32I main control FSM. Decodes the opcode class,
//                drives ALU/PC/regfile/memory controls, waits on memory
//                ready with a bounded timeout and traps on illegal opcodes,
//                ecall/ebreak and memory timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module controller_v2 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  controller_v2_if.master   bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEM       = 3'd4,
    S_WRITEBACK = 3'd5,
    S_TRAP      = 3'd6
  } state_t;

  // Class 0 doubles as the reset value and "unrecognised opcode"
  typedef enum logic [3:0] {
    CL_ILLEGAL = 4'd0,
    CL_LUI     = 4'd1,
    CL_AUIPC   = 4'd2,
    CL_JAL     = 4'd3,
    CL_JALR    = 4'd4,
    CL_BRANCH  = 4'd5,
    CL_LOAD    = 4'd6,
    CL_STORE   = 4'd7,
    CL_OPIMM   = 4'd8,
    CL_OP      = 4'd9,
    CL_FENCE   = 4'd10,
    CL_SYSTEM  = 4'd11
  } class_t;

  localparam logic [1:0] c_CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b10;
  localparam logic [1:0] c_CAUSE_ECALL   = 2'b11;

  state_t           r_state;
  class_t           r_class;
  logic [2:0]       r_funct3;
  logic             r_f7b5;
  logic [CNT_W-1:0] r_cnt;
  logic             r_trap;
  logic [1:0]       r_cause;

  class_t           w_class;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_timeout;
  logic             w_unused;

  // Only funct7[5] carries meaning for RV32I base arithmetic
  assign w_unused = ^{bus.funct7[6], bus.funct7[4:0]};

  // Opcode to instruction-class decode, consumed only in DECODE
  always_comb begin
    w_class = CL_ILLEGAL;
    case (bus.opcode)
      7'b0110111: w_class = CL_LUI;
      7'b0010111: w_class = CL_AUIPC;
      7'b1101111: w_class = CL_JAL;
      7'b1100111: w_class = CL_JALR;
      7'b1100011: w_class = CL_BRANCH;
      7'b0000011: w_class = CL_LOAD;
      7'b0100011: w_class = CL_STORE;
      7'b0010011: w_class = CL_OPIMM;
      7'b0110011: w_class = CL_OP;
      7'b0001111: w_class = CL_FENCE;
      7'b1110011: w_class = CL_SYSTEM;
      default:    w_class = CL_ILLEGAL;
    endcase
  end

  // The trap fires on the wait cycle that would bring the count to the limit;
  // a ready seen in that same cycle is checked first and wins.
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // State, latched instruction fields, wait counter and sticky trap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_class  <= CL_ILLEGAL;
      r_funct3 <= 3'b000;
      r_f7b5   <= 1'b0;
      r_cnt    <= '0;
      r_trap   <= 1'b0;
      r_cause  <= 2'b00;
    end else begin
      // Counter restarts on every state entry; only a held wait keeps it
      r_cnt <= '0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (bus.imem_ready) begin
            r_state <= S_DECODE;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= c_CAUSE_TIMEOUT;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_DECODE: begin
          r_class  <= w_class;
          r_funct3 <= bus.funct3;
          r_f7b5   <= bus.funct7[5];
          case (w_class)
            CL_SYSTEM: begin
              r_state <= S_TRAP;
              r_trap  <= 1'b1;
              r_cause <= c_CAUSE_ECALL;
            end
            CL_ILLEGAL: begin
              r_state <= S_TRAP;
              r_trap  <= 1'b1;
              r_cause <= c_CAUSE_ILLEGAL;
            end
            CL_FENCE: r_state <= S_WRITEBACK;
            default:  r_state <= S_EXECUTE;
          endcase
        end
        S_EXECUTE: begin
          case (r_class)
            CL_BRANCH:          r_state <= S_FETCH;
            CL_LOAD, CL_STORE:  r_state <= S_MEM;
            default:            r_state <= S_WRITEBACK;
          endcase
        end
        S_MEM: begin
          if (bus.dmem_ready) begin
            r_state <= (r_class == CL_STORE) ? S_FETCH : S_WRITEBACK;
          end else if (w_timeout) begin
            r_state <= S_TRAP;
            r_trap  <= 1'b1;
            r_cause <= c_CAUSE_TIMEOUT;
          end else if (TIMEOUT_CYCLES != 0) begin
            r_cnt <= w_cnt_inc;
          end
        end
        S_WRITEBACK: r_state <= S_FETCH;
        S_TRAP:      r_state <= S_TRAP;
        default: begin
          r_state <= S_TRAP;
          r_trap  <= 1'b1;
          r_cause <= c_CAUSE_ILLEGAL;
        end
      endcase
    end
  end

  logic       w_imem_req, w_dmem_req, w_dmem_we, w_ir_write, w_pc_write;
  logic       w_reg_write, w_instret;
  logic [1:0] w_pc_src, w_src_a, w_src_b, w_wb_sel;
  logic [3:0] w_alu_op;

  // Control decode from state and latched class; ir_write, branch pc_src and
  // store retire also look at the live handshake so they land in the same cycle.
  always_comb begin
    w_imem_req  = 1'b0;
    w_dmem_req  = 1'b0;
    w_dmem_we   = 1'b0;
    w_ir_write  = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_src    = 2'b00;
    w_src_a     = 2'b00;
    w_src_b     = 2'b00;
    w_alu_op    = 4'b0000;
    w_reg_write = 1'b0;
    w_wb_sel    = 2'b00;
    w_instret   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        w_ir_write = bus.imem_ready;
      end
      S_EXECUTE: begin
        case (r_class)
          CL_OP:    w_alu_op = {r_f7b5, r_funct3};
          CL_OPIMM: begin
            w_src_b  = 2'b01;
            w_alu_op = {(r_funct3 == 3'b101) ? r_f7b5 : 1'b0, r_funct3};
          end
          CL_LOAD, CL_STORE, CL_JALR: w_src_b = 2'b01;
          CL_LUI: begin
            w_src_a = 2'b10;
            w_src_b = 2'b01;
          end
          CL_AUIPC, CL_JAL: begin
            w_src_a = 2'b01;
            w_src_b = 2'b01;
          end
          CL_BRANCH: begin
            w_alu_op   = 4'b1000;
            w_pc_write = 1'b1;
            w_pc_src   = bus.branch_cond ? 2'b01 : 2'b00;
            w_instret  = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (r_class == CL_STORE);
        if (bus.dmem_ready && (r_class == CL_STORE)) begin
          w_pc_write = 1'b1;
          w_instret  = 1'b1;
        end
      end
      S_WRITEBACK: begin
        w_pc_write  = 1'b1;
        w_instret   = 1'b1;
        w_reg_write = (r_class != CL_FENCE);
        case (r_class)
          CL_LOAD:         w_wb_sel = 2'b01;
          CL_JAL, CL_JALR: w_wb_sel = 2'b10;
          default:         w_wb_sel = 2'b00;
        endcase
        case (r_class)
          CL_JAL:  w_pc_src = 2'b01;
          CL_JALR: w_pc_src = 2'b10;
          default: w_pc_src = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.imem_req   = w_imem_req;
  assign bus.dmem_req   = w_dmem_req;
  assign bus.dmem_we    = w_dmem_we;
  assign bus.ir_write   = w_ir_write;
  assign bus.pc_write   = w_pc_write;
  assign bus.pc_src     = w_pc_src;
  assign bus.alu_src_a  = w_src_a;
  assign bus.alu_src_b  = w_src_b;
  assign bus.alu_op     = w_alu_op;
  assign bus.reg_write  = w_reg_write;
  assign bus.wb_sel     = w_wb_sel;
  assign bus.instret    = w_instret;
  assign bus.trap       = r_trap;
  assign bus.trap_cause = r_cause;
  assign bus.state_vec  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_controller_v2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_controller_v2
//  Description : Directed bench for controller_v2 (TIMEOUT_CYCLES = 4):
//                per-instruction vector table plus reset/trap sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_controller_v2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controller_v2_if bus ();

  controller_v2 #(.TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bc;
    int         iw;      // imem wait cycles before ready
    int         dw;      // dmem wait cycles before ready
    logic [2:0] st_dec;  // state after DECODE
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] op;
    logic       ex_pcw;
    logic [1:0] ex_pcs;
    logic [2:0] st_ex;   // state after EXECUTE
    logic       we;
    logic       wb_rw;
    logic [1:0] wb_sel;
    logic [1:0] wb_pcs;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] outs();
    return {bus.imem_req, bus.dmem_req, bus.dmem_we, bus.ir_write, bus.pc_write,
            bus.pc_src, bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write,
            bus.wb_sel, bus.instret, bus.trap, bus.trap_cause, bus.state_vec};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.start       = 1'b0;
    bus.opcode      = 7'h00;
    bus.funct3      = 3'h0;
    bus.funct7      = 7'h00;
    bus.branch_cond = 1'b0;
    bus.imem_ready  = 1'b0;
    bus.dmem_ready  = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk({tag, "_in_reset"}, 32'(outs()), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk({tag, "_after_reset"}, 32'(outs()), 32'h0);
  endtask

  task automatic go_fetch();
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    #1;
    chk("start_to_fetch", 32'(bus.state_vec), 32'd1);
  endtask

  // Runs one instruction starting in FETCH; ends back in FETCH (or TRAP)
  task automatic run_vec(input vec_t v);
    bus.opcode      = v.opc;
    bus.funct3      = v.f3;
    bus.funct7      = v.f7;
    bus.branch_cond = v.bc;
    bus.imem_ready  = 1'b0;
    for (int w = 0; w < v.iw; w++) begin
      #1;
      chk({v.name, "_fetch_wait_state"}, 32'(bus.state_vec), 32'd1);
      chk({v.name, "_fetch_wait_req_irw"}, 32'({bus.imem_req, bus.ir_write}), 32'b10);
      cyc();
    end
    bus.imem_ready = 1'b1;
    #1;
    chk({v.name, "_fetch_ready_req_irw"}, 32'({bus.imem_req, bus.ir_write}), 32'b11);
    cyc();
    bus.imem_ready = 1'b0;
    #1;
    chk({v.name, "_decode_state"}, 32'(bus.state_vec), 32'd2);
    cyc();
    // Scramble IR fields: later states must rely on latched values
    bus.opcode = 7'h00;
    bus.funct3 = 3'h0;
    bus.funct7 = 7'h00;
    #1;
    chk({v.name, "_after_decode"}, 32'(bus.state_vec), 32'(v.st_dec));
    if (v.st_dec == 3'd3) begin
      chk({v.name, "_ex_alu"}, 32'({bus.alu_src_a, bus.alu_src_b, bus.alu_op}),
          32'({v.a, v.b, v.op}));
      chk({v.name, "_ex_pc"}, 32'({bus.pc_write, bus.pc_src, bus.instret, bus.reg_write}),
          32'({v.ex_pcw, v.ex_pcs, v.ex_pcw, 1'b0}));
      cyc();
      #1;
      chk({v.name, "_after_execute"}, 32'(bus.state_vec), 32'(v.st_ex));
    end
    if (bus.state_vec == 3'd4) begin
      for (int w = 0; w < v.dw; w++) begin
        chk({v.name, "_mem_wait"}, 32'({bus.dmem_req, bus.dmem_we, bus.instret, bus.pc_write}),
            32'({1'b1, v.we, 2'b00}));
        cyc();
        #1;
      end
      bus.dmem_ready = 1'b1;
      #1;
      chk({v.name, "_mem_ready"},
          32'({bus.dmem_req, bus.dmem_we, bus.instret, bus.pc_write, bus.pc_src, bus.reg_write}),
          32'({1'b1, v.we, v.we, v.we, 2'b00, 1'b0}));
      cyc();
      bus.dmem_ready = 1'b0;
      #1;
      chk({v.name, "_after_mem"}, 32'(bus.state_vec), v.we ? 32'd1 : 32'd5);
    end
    if (bus.state_vec == 3'd5) begin
      chk({v.name, "_wb"},
          32'({bus.reg_write, bus.wb_sel, bus.pc_src, bus.pc_write, bus.instret}),
          32'({v.wb_rw, v.wb_sel, v.wb_pcs, 2'b11}));
      cyc();
      #1;
      chk({v.name, "_after_wb"}, 32'(bus.state_vec), 32'd1);
    end
  endtask

  task automatic run_trap(input string tag, input logic [6:0] opc, input logic [1:0] cause);
    do_reset(tag);
    go_fetch();
    bus.opcode     = opc;
    bus.imem_ready = 1'b1;
    cyc();
    bus.imem_ready = 1'b0;
    cyc();
    #1;
    chk({tag, "_trap"}, 32'({bus.state_vec, bus.trap, bus.trap_cause}), 32'({3'd6, 1'b1, cause}));
    chk({tag, "_trap_quiet"}, 32'({bus.imem_req, bus.instret, bus.pc_write, bus.reg_write}), 32'h0);
  endtask

  initial begin
    //          name        opc          f3      f7           bc iw dw dec   a      b      op       pcw pcs    ex    we wrw sel    pcs
    vecs[0]  = '{"op_sub",   7'b0110011, 3'b000, 7'b0100000, 0, 3, 0, 3'd3, 2'b00, 2'b00, 4'b1000, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[1]  = '{"op_add",   7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, 3'd3, 2'b00, 2'b00, 4'b0000, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[2]  = '{"op_sra",   7'b0110011, 3'b101, 7'b0100000, 0, 1, 0, 3'd3, 2'b00, 2'b00, 4'b1101, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[3]  = '{"op_and",   7'b0110011, 3'b111, 7'b0000000, 0, 2, 0, 3'd3, 2'b00, 2'b00, 4'b0111, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[4]  = '{"srai",     7'b0010011, 3'b101, 7'b0100000, 0, 0, 0, 3'd3, 2'b00, 2'b01, 4'b1101, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[5]  = '{"addi",     7'b0010011, 3'b000, 7'b0100000, 0, 0, 0, 3'd3, 2'b00, 2'b01, 4'b0000, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[6]  = '{"lui",      7'b0110111, 3'b000, 7'b0000000, 0, 0, 0, 3'd3, 2'b10, 2'b01, 4'b0000, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[7]  = '{"auipc",    7'b0010111, 3'b000, 7'b0000000, 0, 0, 0, 3'd3, 2'b01, 2'b01, 4'b0000, 0, 2'b00, 3'd5, 0, 1, 2'b00, 2'b00};
    vecs[8]  = '{"jal",      7'b1101111, 3'b000, 7'b0000000, 0, 0, 0, 3'd3, 2'b01, 2'b01, 4'b0000, 0, 2'b00, 3'd5, 0, 1, 2'b10, 2'b01};
    vecs[9]  = '{"jalr",     7'b1100111, 3'b000, 7'b0000000, 0, 0, 0, 3'd3, 2'b00, 2'b01, 4'b0000, 0, 2'b00, 3'd5, 0, 1, 2'b10, 2'b10};
    vecs[10] = '{"br_taken", 7'b1100011, 3'b000, 7'b0000000, 1, 0, 0, 3'd3, 2'b00, 2'b00, 4'b1000, 1, 2'b01, 3'd1, 0, 0, 2'b00, 2'b00};
    vecs[11] = '{"br_not",   7'b1100011, 3'b001, 7'b0000000, 0, 0, 0, 3'd3, 2'b00, 2'b00, 4'b1000, 1, 2'b00, 3'd1, 0, 0, 2'b00, 2'b00};
    vecs[12] = '{"load",     7'b0000011, 3'b010, 7'b0000000, 0, 0, 2, 3'd3, 2'b00, 2'b01, 4'b0000, 0, 2'b00, 3'd4, 0, 1, 2'b01, 2'b00};
    vecs[13] = '{"store",    7'b0100011, 3'b010, 7'b0000000, 0, 0, 3, 3'd3, 2'b00, 2'b01, 4'b0000, 0, 2'b00, 3'd4, 1, 0, 2'b00, 2'b00};
    vecs[14] = '{"fence",    7'b0001111, 3'b000, 7'b0000000, 0, 1, 0, 3'd5, 2'b00, 2'b00, 4'b0000, 0, 2'b00, 3'd5, 0, 0, 2'b00, 2'b00};

    // Reset state, IDLE hold, and asynchronous reset in the middle of FETCH
    do_reset("por");
    cyc();
    #1;
    chk("idle_holds", 32'(bus.state_vec), 32'd0);
    go_fetch();
    chk("fetch_imem_req", 32'(bus.imem_req), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_drops_req", 32'({bus.imem_req, bus.state_vec}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("after_async_rst", 32'(outs()), 32'h0);

    // Instruction table, back to back from one start
    go_fetch();
    foreach (vecs[i]) run_vec(vecs[i]);

    // Fetch timeout: four wait cycles then TRAP; start ignored; reset clears
    bus.imem_ready = 1'b0;
    for (int w = 0; w < 4; w++) begin
      #1;
      chk("to_fetch_waiting", 32'(bus.state_vec), 32'd1);
      cyc();
    end
    #1;
    chk("to_fetch_trap", 32'({bus.state_vec, bus.trap, bus.trap_cause, bus.imem_req}),
        32'({3'd6, 1'b1, 2'b10, 1'b0}));
    bus.start = 1'b1;
    cyc();
    cyc();
    #1;
    chk("trap_ignores_start", 32'({bus.state_vec, bus.trap, bus.trap_cause, bus.instret}),
        32'({3'd6, 1'b1, 2'b10, 1'b0}));
    do_reset("trap_exit");

    // Data-memory timeout on a load
    go_fetch();
    bus.opcode     = 7'b0000011;
    bus.imem_ready = 1'b1;
    cyc();
    bus.imem_ready = 1'b0;
    cyc();
    cyc();
    #1;
    chk("to_mem_entry", 32'(bus.state_vec), 32'd4);
    for (int w = 0; w < 3; w++) begin
      cyc();
      #1;
    end
    chk("to_mem_still_waiting", 32'({bus.state_vec, bus.dmem_req}), 32'({3'd4, 1'b1}));
    cyc();
    #1;
    chk("to_mem_trap", 32'({bus.state_vec, bus.trap_cause, bus.dmem_req}), 32'({3'd6, 2'b10, 1'b0}));

    // Decode traps
    run_trap("illegal", 7'b1111111, 2'b01);
    run_trap("ecall", 7'b1110011, 2'b11);
    do_reset("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
